// File: rtl/sh7604_dbus_arbiter_pkg.sv
// Shared types and helpers for the SH7604 internal data-bus arbiter.
package sh7604_dbus_arbiter_pkg;

    // Current owner of the internal data bus; the encoding is exported on BUS_OWNER.
    typedef enum logic [1:0] {
        DBO_IDLE = 2'd0,
        DBO_CPU  = 2'd1,
        DBO_DMA  = 2'd2
    } DBUS_OWNER_t;

    // One master's request as seen by the mux; the CPU has no burst mode.
    typedef struct packed {
        logic [31:0] A;
        logic [31:0] DO;
        logic [3:0]  BA;
        logic        WE;
        logic        REQ;
        logic        LOCK;
        logic        BURST;
    } DBUS_MST_t;

    localparam DBUS_MST_t DBUS_MST_NONE = '0;

    // Selects the owning master's request; an idle bus presents all zeros.
    function automatic DBUS_MST_t dbus_select(input DBUS_OWNER_t own,
                                              input DBUS_MST_t   cpu,
                                              input DBUS_MST_t   dma);
        case (own)
            DBO_CPU: return cpu;
            DBO_DMA: return dma;
            default: return DBUS_MST_NONE;
        endcase
    endfunction

    // An owner gives up the bus when an unlocked access completes on the
    // falling phase, or when it is no longer requesting on the rising phase.
    // A held LOCK keeps the bus across read/write gaps and burst beats.
    function automatic logic dbus_release(input DBUS_MST_t own_m,
                                          input logic      ce_r,
                                          input logic      ce_f,
                                          input logic      bus_wait);
        logic done_f;
        logic idle_r;
        done_f = ce_f & own_m.REQ & ~bus_wait & ~own_m.LOCK;
        idle_r = ce_r & ~own_m.REQ & ~own_m.LOCK;
        return done_f | idle_r;
    endfunction

endpackage

// File: rtl/sh7604_dbus_arbiter_if.sv
// Bundle of CPU, DMAC and BSC-side data-bus signals around the arbiter.
interface sh7604_dbus_arbiter_if;

    // CPU core side
    logic [31:0] CPU_A;
    logic [31:0] CPU_DO;
    logic [3:0]  CPU_BA;
    logic        CPU_WE;
    logic        CPU_REQ;
    logic        CPU_LOCK;
    logic [31:0] CPU_DI;
    logic        CPU_WAIT;

    // DMAC side
    logic [31:0] DMA_A;
    logic [31:0] DMA_DO;
    logic [3:0]  DMA_BA;
    logic        DMA_WE;
    logic        DMA_REQ;
    logic        DMA_LOCK;
    logic        DMA_BURST;
    logic [31:0] DMA_DI;
    logic        DMA_WAIT;

    // Bus state controller side
    logic [31:0] BUS_A;
    logic [31:0] BUS_DO;
    logic [3:0]  BUS_BA;
    logic        BUS_WE;
    logic        BUS_REQ;
    logic        BUS_BURST;
    logic [31:0] BUS_DI;
    logic        BUS_WAIT;
    logic        BSC_ACK;
    logic [1:0]  BUS_OWNER;

    // Arbiter view: takes master requests and BSC responses, drives the rest.
    modport slave (
        input  CPU_A, CPU_DO, CPU_BA, CPU_WE, CPU_REQ, CPU_LOCK,
        output CPU_DI, CPU_WAIT,
        input  DMA_A, DMA_DO, DMA_BA, DMA_WE, DMA_REQ, DMA_LOCK, DMA_BURST,
        output DMA_DI, DMA_WAIT,
        output BUS_A, BUS_DO, BUS_BA, BUS_WE, BUS_REQ, BUS_BURST,
        input  BUS_DI, BUS_WAIT,
        output BSC_ACK, BUS_OWNER
    );

    // Environment view: the CPU, DMAC and BSC that surround the arbiter.
    modport master (
        output CPU_A, CPU_DO, CPU_BA, CPU_WE, CPU_REQ, CPU_LOCK,
        input  CPU_DI, CPU_WAIT,
        output DMA_A, DMA_DO, DMA_BA, DMA_WE, DMA_REQ, DMA_LOCK, DMA_BURST,
        input  DMA_DI, DMA_WAIT,
        input  BUS_A, BUS_DO, BUS_BA, BUS_WE, BUS_REQ, BUS_BURST,
        output BUS_DI, BUS_WAIT,
        input  BSC_ACK, BUS_OWNER
    );

endinterface

// File: rtl/sh7604_dbus_arbiter.sv
// SH7604 internal data-bus arbiter: CPU core vs DMAC in front of the BSC.
// Only the owner and the fairness flag are registered; every bus, wait and
// data path is combinational from the owner.
module sh7604_dbus_arbiter
    import sh7604_dbus_arbiter_pkg::*;
#(
    parameter bit CPU_FAIR = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CE_R,
    input  logic                 CE_F,
    sh7604_dbus_arbiter_if.slave dbus
);

    DBUS_OWNER_t own_q;
    DBUS_OWNER_t own_d;
    logic        last_dma_q;
    logic        last_dma_d;

    DBUS_MST_t   cpu_m;
    DBUS_MST_t   dma_m;
    DBUS_MST_t   own_m;
    logic        release_own;
    logic        cpu_first;

    assign cpu_m = '{A:     dbus.CPU_A,
                     DO:    dbus.CPU_DO,
                     BA:    dbus.CPU_BA,
                     WE:    dbus.CPU_WE,
                     REQ:   dbus.CPU_REQ,
                     LOCK:  dbus.CPU_LOCK,
                     BURST: 1'b0};

    assign dma_m = '{A:     dbus.DMA_A,
                     DO:    dbus.DMA_DO,
                     BA:    dbus.DMA_BA,
                     WE:    dbus.DMA_WE,
                     REQ:   dbus.DMA_REQ,
                     LOCK:  dbus.DMA_LOCK,
                     BURST: dbus.DMA_BURST};

    assign own_m       = dbus_select(own_q, cpu_m, dma_m);
    assign release_own = dbus_release(own_m, CE_R, CE_F, dbus.BUS_WAIT);
    // After an unlocked DMA ownership a waiting CPU goes ahead of the next DMA request.
    assign cpu_first   = CPU_FAIR && last_dma_q;

    // Owner and fairness flag; reset drops the bus immediately, mid-access included.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: registered state is written with non-blocking assignments only.
        if (!RST_N) begin
            own_q      <= DBO_IDLE;
            last_dma_q <= 1'b0;
        end else begin
            own_q      <= own_d;
            last_dma_q <= last_dma_d;
        end
    end

    // Next owner: arbitrate on the rising phase when idle, release per owner's lock/completion.
    always_comb begin
        // NOTE: hold-value defaults first, so no branch leaves a signal unassigned.
        own_d      = own_q;
        last_dma_d = last_dma_q;

        if (own_q == DBO_IDLE) begin
            if (CE_R) begin
                if (dma_m.REQ && !(cpu_m.REQ && cpu_first)) begin
                    own_d = DBO_DMA;
                end else if (cpu_m.REQ) begin
                    own_d = DBO_CPU;
                end
            end
        end else if (release_own) begin
            own_d = DBO_IDLE;
        end

        // Releases only happen unlocked, so any DMA-to-idle step marks DMA as last.
        if (own_q == DBO_DMA && own_d == DBO_IDLE) begin
            last_dma_d = 1'b1;
        end
        if (own_q != DBO_CPU && own_d == DBO_CPU) begin
            last_dma_d = 1'b0;
        end
    end

    // Bus mux, wait steering, read-data fan-out and DACK timing, all from the current owner.
    always_comb begin
        dbus.BUS_A     = own_m.A;
        dbus.BUS_DO    = own_m.DO;
        dbus.BUS_BA    = own_m.BA;
        dbus.BUS_WE    = own_m.WE;
        dbus.BUS_REQ   = own_m.REQ;
        dbus.BUS_BURST = own_m.BURST;
        dbus.BUS_OWNER = own_q;

        dbus.BSC_ACK   = (own_q == DBO_DMA) && dbus.DMA_REQ;

        // The owner follows the BSC; a master that does not own the bus is
        // stalled for exactly as long as it keeps requesting.
        dbus.CPU_WAIT  = (own_q == DBO_CPU) ? dbus.BUS_WAIT : dbus.CPU_REQ;
        dbus.DMA_WAIT  = (own_q == DBO_DMA) ? dbus.BUS_WAIT : dbus.DMA_REQ;

        dbus.CPU_DI    = dbus.BUS_DI;
        dbus.DMA_DI    = dbus.BUS_DI;
    end

endmodule

// File: doc/sh7604_dbus_arbiter.md
# sh7604_dbus_arbiter

Arbitrates the SH7604 internal data bus between the CPU core and the DMAC, producing the single request stream consumed by the bus state controller (BSC). It sits directly downstream of the DMAC `DBUS_*` port and upstream of the BSC. It does three things:
- holds grants across locked and burst sequences;
- returns `BUS_WAIT` to the owning master and stalls the other one;
- generates `BSC_ACK` for DMAC DACK timing.

## Interface
Parameters:
- `CPU_FAIR`, default 1: when 1, a CPU request pending at the end of an unlocked DMA ownership is granted before the next DMA request. When 0, DMA has fixed priority.

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: reset, asynchronous, active-low.
- `CE_R`, `CE_F` in 1: rising/falling phase clock enables.
- `CPU_A` in 32, `CPU_DO` in 32, `CPU_BA` in 4, `CPU_WE` in 1, `CPU_REQ` in 1, `CPU_LOCK` in 1: CPU access (`CPU_LOCK` is for TAS-style read-modify-write).
- `CPU_DI` out 32: read data to CPU.
- `CPU_WAIT` out 1: stall to CPU.
- `DMA_A` in 32, `DMA_DO` in 32, `DMA_BA` in 4, `DMA_WE` in 1, `DMA_REQ` in 1, `DMA_LOCK` in 1, `DMA_BURST` in 1: DMAC access.
- `DMA_DI` out 32: read data to DMAC.
- `DMA_WAIT` out 1: stall to DMAC.
- `BSC_ACK` out 1: DMA access in flight on the bus.
- `BUS_A` out 32, `BUS_DO` out 32, `BUS_BA` out 4, `BUS_WE` out 1, `BUS_REQ` out 1, `BUS_BURST` out 1: to BSC.
- `BUS_DI` in 32, `BUS_WAIT` in 1: from BSC.
- `BUS_OWNER` out 2: 0 = idle, 1 = CPU, 2 = DMA.

## Operation
- State register `OWN` ∈ {IDLE, CPU, DMA}.
- `LAST_DMA` flag is set when a DMA ownership ends unlocked and cleared when the CPU is granted.

Arbitration, evaluated only on `CE_R` while `OWN=IDLE`:
- Only one master requesting: grant it.
- Both requesting: grant DMA, unless `CPU_FAIR=1` and `LAST_DMA=1`, in which case grant CPU.

Bus mux:
- `BUS_*` = owner's signals.
- `BUS_REQ` = owner `REQ`.
- `BUS_BURST` = `DMA_BURST` when `OWN=DMA`, else 0.
- When `OWN=IDLE`, all `BUS_*` outputs are 0.

Wait and data:
- Owner `WAIT` = `BUS_WAIT`.
- Non-owner `WAIT` = its own `REQ`.
- In IDLE, both `WAIT` = their own `REQ`.
- `CPU_DI` = `DMA_DI` = `BUS_DI`, unconditionally.

Other outputs:
- `BSC_ACK` = (`OWN=DMA`) & `DMA_REQ`.
- `BUS_OWNER` reflects `OWN` directly.

Release, evaluated on `CE_F`, for an owner with `REQ=1` and `BUS_WAIT=0` (access completes):
- Owner `LOCK=0`: `OWN`←IDLE.
- Owner `LOCK=1`: ownership held.

Release, evaluated on `CE_R`, for an owner with `REQ=0`:
- `LOCK=0`: `OWN`←IDLE.
- `LOCK=1`: ownership held, so DMAC read→write gaps keep the bus.

## Timing
- Reset values:
  - `OWN`=IDLE, `LAST_DMA`=0.
  - `BUS_A`, `BUS_DO`, `BUS_BA`, `BUS_WE`, `BUS_REQ`, `BUS_BURST`, `BSC_ACK`, `BUS_OWNER` = 0.
  - `CPU_WAIT`=`CPU_REQ`, `DMA_WAIT`=`DMA_REQ`.
- Grant latency: a request seen at a `CE_R` in IDLE drives `BUS_REQ` in the following cycle, so the first access completes at the earliest on the next `CE_F`.
- Handover after an unlocked completion: IDLE for at least until the next `CE_R`, then re-arbitrate. This is a one-phase bubble, which is required.
- Locked or burst sequences (DMAC 16-byte: `DMA_LOCK`=`DMA_BURST`=1 for 4 beats): no bubble, and the CPU stays stalled throughout.
- Simultaneous completion on `CE_F` and new request on the same cycle: release takes effect first; the new request is arbitrated on the next `CE_R`.
- `RST_N` asserted mid-access: immediate return to IDLE; `BUS_REQ` drops asynchronously. Masters are reset by the same `RST_N`.
- All mux and wait paths are combinational from `OWN`; only `OWN` and `LAST_DMA` are registered.

## Structure
- `SH7604_PKG` additions:
  - `typedef enum logic [1:0] {DBO_IDLE, DBO_CPU, DBO_DMA} DBUS_OWNER_t`.
  - `typedef struct` `DBUS_MST_t` {`A`, `DO`, `BA`, `WE`, `REQ`, `LOCK`, `BURST`} for the mux.
- No sub-module. Single arbiter FSM plus combinational mux (~150 lines).

## Test plan
- CPU-only read, `CPU_A`=0x06000010, `BUS_WAIT` low: `BUS_OWNER`=1 one cycle after `CE_R`; `CPU_DI`=`BUS_DI`=0x12345678; `OWN` returns to IDLE after `CE_F`.
- `CPU_REQ` and `DMA_REQ` raised on the same `CE_R`, `CPU_FAIR`=1, `LAST_DMA`=0: DMA granted and `CPU_WAIT`=1. After the DMA unlocked write completes, CPU is granted next even though `DMA_REQ` is still 1.
- DMA 16-byte burst with `DMA_LOCK`=`DMA_BURST`=1, 4 reads then 4 writes, `BUS_WAIT` held 2 cycles per beat: `BUS_OWNER`=2 continuously; `CPU_WAIT`=1 throughout; `BUS_BURST`=1; `BSC_ACK` high on every beat.
- CPU TAS with `CPU_LOCK`=1 across read and write, DMA requesting: DMA is not granted until the CPU write completes with `CPU_LOCK`=0.
- `RST_N` pulsed low while `BUS_WAIT`=1 on a DMA access: `BUS_REQ`=0 and `BUS_OWNER`=0 immediately; after release, a pending `CPU_REQ` is granted first (`LAST_DMA`=0).
